nios_ii_system_hex_ctrl: RTL and testbench



---
 rtl/nios_ii_system_hex_ctrl_if.sv | 25 ++
 rtl/nios_ii_system_hex_ctrl.sv | 135 +++++++++++++
 tb/tb_nios_ii_system_hex_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/nios_ii_system_hex_ctrl_if.sv
// Avalon-MM slave port bundle for the hex display controller.
// The master drives address/strobes/data and the slave returns combinational readdata.
interface nios_ii_system_hex_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_ii_system_hex_ctrl.sv
// Seven-segment controller: packed hex VALUE word, per-digit enable and hardware blink,
// driving active-low segment pins through a registered out_port.
module nios_ii_system_hex_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int PERIOD_W    = 24,
    parameter int BLINK_RESET = 12500000
) (
    input  logic                      clk,
    input  logic                      reset,
    nios_ii_system_hex_ctrl_if.slave  bus,
    output logic [7*NUM_DIGITS-1:0]   out_port
);

    localparam int VALUE_W = 4 * NUM_DIGITS;
    localparam int OUT_W   = 7 * NUM_DIGITS;
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(32'd1);
    localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(BLINK_RESET);

    logic [VALUE_W-1:0]    value_r;
    logic [NUM_DIGITS-1:0] enable_r;
    logic [NUM_DIGITS-1:0] mask_r;
    logic [PERIOD_W-1:0]   period_r;
    logic [PERIOD_W-1:0]   count_r;
    logic                  phase_r;
    logic [OUT_W-1:0]      out_port_r;
    logic [OUT_W-1:0]      out_next_s;
    logic [31:0]           rdata_s;
    logic                  wr_s;
    logic                  wr_value_s;
    logic                  wr_enable_s;
    logic                  wr_mask_s;
    logic                  wr_period_s;
    logic                  unused_wdata_s;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign wr_s           = bus.chipselect & ~bus.write_n;
    assign wr_value_s     = wr_s & (bus.address == 2'd0);
    assign wr_enable_s    = wr_s & (bus.address == 2'd1);
    assign wr_mask_s      = wr_s & (bus.address == 2'd2);
    assign wr_period_s    = wr_s & (bus.address == 2'd3);
    assign unused_wdata_s = ^bus.writedata;

    // Software-visible control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_r  <= '0;
            enable_r <= '1;
            mask_r   <= '0;
            period_r <= PERIOD_RST;
        end else begin
            if (wr_value_s)  value_r  <= bus.writedata[VALUE_W-1:0];
            if (wr_enable_s) enable_r <= bus.writedata[NUM_DIGITS-1:0];
            if (wr_mask_s)   mask_r   <= bus.writedata[NUM_DIGITS-1:0];
            if (wr_period_s) period_r <= bus.writedata[PERIOD_W-1:0];
        end
    end

    // Blink timebase; a period write restarts it and overrides a coincident wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
            phase_r <= 1'b0;
        end else if (wr_period_s || (period_r == '0)) begin
            count_r <= '0;
            phase_r <= 1'b0;
        end else if (count_r == (period_r - PERIOD_ONE)) begin
            count_r <= '0;
            phase_r <= ~phase_r;
        end else begin
            count_r <= count_r + PERIOD_ONE;
        end
    end

    // Next segment image from current register and phase state.
    always_comb begin
        out_next_s = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (enable_r[i] && !(mask_r[i] && phase_r)) begin
                out_next_s[7*i +: 7] = hex_decode(value_r[4*i +: 4]);
            end else begin
                out_next_s[7*i +: 7] = 7'h7F;
            end
        end
    end

    // Registered pin drive, blank while in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port_r <= '1;
        end else begin
            out_port_r <= out_next_s;
        end
    end

    assign out_port = out_port_r;

    // Zero-latency read mux.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.address)
            2'd0:    rdata_s = 32'(value_r);
            2'd1:    rdata_s = 32'(enable_r);
            2'd2:    rdata_s = 32'(mask_r);
            2'd3:    rdata_s = {phase_r, 31'(period_r)};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    assign bus.readdata = rdata_s;

endmodule

// File: tb/tb_nios_ii_system_hex_ctrl.sv
// Scoreboard bench: a tick-count reference model predicts out_port and readdata,
// a negedge monitor pops and compares.
module tb_nios_ii_system_hex_ctrl;
    localparam int N     = 4;
    localparam int PW    = 24;
    localparam int OW    = 7 * N;
    localparam int BRST  = 12500000;
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E };

    logic clk = 1'b0;
    logic reset;
    logic [OW-1:0] out_port;
    always #5 clk = ~clk;

    nios_ii_system_hex_ctrl_if bus();

    nios_ii_system_hex_ctrl #(.NUM_DIGITS(N), .PERIOD_W(PW), .BLINK_RESET(BRST)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    int checks = 0;
    int passed = 0;
    logic [OW-1:0] out_q [$];
    logic [31:0]   rd_q  [$];

    // Reference model: registers plus clock edges since the blink timebase was cleared.
    logic [4*N-1:0] m_value;
    logic [N-1:0]   m_en;
    logic [N-1:0]   m_mask;
    logic [PW-1:0]  m_period;
    longint         m_ticks;

    function automatic bit m_phase();
        if (m_period == '0) return 1'b0;
        return ((m_ticks / longint'(m_period)) % 2) == 1;
    endfunction

    function automatic logic [OW-1:0] m_out();
        logic [OW-1:0] r;
        bit ph;
        ph = m_phase();
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && !(m_mask[i] && ph)) r[7*i +: 7] = SEG_TBL[m_value[4*i +: 4]];
            else                                r[7*i +: 7] = 7'h7F;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_value);
            2'd1:    return 32'(m_en);
            2'd2:    return 32'(m_mask);
            default: return {m_phase(), 7'd0, m_period};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    always @(posedge reset) begin
        m_value  <= '0;
        m_en     <= '1;
        m_mask   <= '0;
        m_period <= PW'(BRST);
        m_ticks  <= 0;
    end

    // Predict the image each edge produces, then apply the bus write seen at that edge.
    always @(posedge clk) begin
        if (reset) begin
            out_q.push_back('1);
            m_value  <= '0;
            m_en     <= '1;
            m_mask   <= '0;
            m_period <= PW'(BRST);
            m_ticks  <= 0;
        end else begin
            out_q.push_back(m_out());
            if (bus.chipselect && !bus.write_n && bus.address == 2'd3) begin
                m_period <= bus.writedata[PW-1:0];
                m_ticks  <= 0;
            end else begin
                m_ticks <= m_ticks + 1;
                if (bus.chipselect && !bus.write_n) begin
                    case (bus.address)
                        2'd0:    m_value <= bus.writedata[4*N-1:0];
                        2'd1:    m_en    <= bus.writedata[N-1:0];
                        default: m_mask  <= bus.writedata[N-1:0];
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_q.size() > 0) check("out_port", 32'(out_port), 32'(out_q.pop_front()));
        if (rd_q.size() > 0)  check($sformatf("readdata@%0d", bus.address), bus.readdata, rd_q.pop_front());
    end

    // Each task presents one cycle of bus activity starting just after a rising edge.
    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [1:0] a);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.writedata = $urandom;
        rd_q.push_back(m_read(a));
        @(posedge clk); #1;
    endtask

    task automatic do_idle();
        bus.address = 2'($urandom); bus.chipselect = 1'b0; bus.write_n = 1'($urandom);
        bus.writedata = $urandom;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        reset = 1'b1;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
        repeat (2) @(negedge clk);
        #1 check("reset_blank", 32'(out_port), 32'(28'hFFFFFFF));
        reset = 1'b0;
        @(posedge clk); #1;

        // reset values
        do_idle(); do_idle();
        do_read(2'd1); do_read(2'd3); do_read(2'd0); do_read(2'd2);

        // value decode and enable masking
        do_write(2'd0, 32'h0000A5F3); do_idle(); do_read(2'd0);
        do_write(2'd1, 32'hFFFF_FFF5); do_idle(); do_read(2'd1);
        do_write(2'd0, 32'hDEAD_C0DE); do_read(2'd0);

        // blinking digit 0 with period 3
        do_write(2'd1, 32'h0000_000F);
        do_write(2'd2, 32'h0000_0001);
        do_write(2'd3, 32'h0000_0003);
        repeat (14) do_read(2'd3);

        // period write coinciding with a wrap
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            if ((m_ticks % 3) == 2) hit = 1'b1;
            else do_read(2'd3);
        end
        check("wrap_align", 32'(hit), 32'd1);
        do_write(2'd3, 32'h0000_0003);
        repeat (4) do_read(2'd3);
        do_write(2'd3, 32'h0000_0000);
        repeat (8) do_read(2'd3);

        // reset mid-blink while hidden
        do_write(2'd3, 32'h0000_0003);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            if (m_phase()) hit = 1'b1;
            else do_read(2'd3);
        end
        check("phase_hidden", 32'(hit), 32'd1);
        @(negedge clk); #1;
        reset = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b0; bus.writedata = 32'h1234_5678;
        #1 check("reset_async", 32'(out_port), 32'(28'hFFFFFFF));
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b0; bus.writedata = 32'hFFFF_FFFF;
        repeat (3) begin @(posedge clk); #1; end
        do_read(2'd0); do_read(2'd1); do_read(2'd2); do_read(2'd3);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 3) begin
                logic [1:0] a;
                a = 2'($urandom);
                if (a == 2'd3) do_write(a, {8'($urandom), 16'h0, 8'($urandom_range(0, 5))});
                else           do_write(a, $urandom);
            end else if (op <= 6) begin
                do_read(2'($urandom));
            end else begin
                do_idle();
            end
        end
        repeat (3) do_idle();
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
